lsu_rmw: RTL and testbench

//  Load/store unit between the core datapath and the word-wide data memory.

---
 rtl/lsu_rmw_pkg.sv | 22 ++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/lsu_rmw.sv | 139 +++++++++++++
 tb/tb_lsu_rmw.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_rmw_pkg.sv
// Shared load/store definitions: funct3 encodings for memory accesses and
// the FSM state encoding used by lsu_rmw.
package lsu_rmw_pkg;

   typedef logic [2:0] funct3_t;

   localparam funct3_t F3_BYTE   = 3'b000;
   localparam funct3_t F3_HALF   = 3'b001;
   localparam funct3_t F3_WORD   = 3'b010;
   localparam funct3_t F3_BYTE_U = 3'b100;
   localparam funct3_t F3_HALF_U = 3'b101;

   typedef logic [2:0] lsu_state_t;

   localparam lsu_state_t S_IDLE = 3'd0;
   localparam lsu_state_t S_RD   = 3'd1;
   localparam lsu_state_t S_CAP  = 3'd2;
   localparam lsu_state_t S_WR   = 3'd3;
   localparam lsu_state_t S_RESP = 3'd4;
   localparam lsu_state_t S_ERR  = 3'd5;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling on a 32-bit word: load extraction with
// sign/zero extension, store lane merge, and legality check of an access.
module lsu_lane_align
   import lsu_rmw_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  funct3_t     funct3,
   input  logic        we,
   output logic [31:0] load_data,
   output logic [31:0] merged,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the read word
   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = word[{addr_lo[1], 4'b0000} +: 16];
   end

   // Extend the selected lane into a full load result
   always_comb begin
      load_data = '0;
      case (funct3)
         F3_BYTE:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BYTE_U: load_data = {24'h0, byte_sel};
         F3_HALF:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_HALF_U: load_data = {16'h0, half_sel};
         F3_WORD:   load_data = word;
         default:   load_data = '0;
      endcase
   end

   // Replace only the addressed lane; a word store passes wdata straight through
   always_comb begin
      merged = word;
      case (funct3)
         F3_BYTE: merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
         F3_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

   // Unsigned variants are load-only; unused encodings are always rejected
   always_comb begin
      misaligned = 1'b1;
      case (funct3)
         F3_BYTE:   misaligned = 1'b0;
         F3_BYTE_U: misaligned = we;
         F3_HALF:   misaligned = addr_lo[0];
         F3_HALF_U: misaligned = we | addr_lo[0];
         F3_WORD:   misaligned = |addr_lo;
         default:   misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit adding byte/halfword access and read-modify-write stores
// on top of a word-only memory with one cycle of read latency.
//
//  state  | meaning
//  IDLE   | ready for a request; legality decided at accept
//  RD     | word address presented to memory
//  CAP    | read word valid; register load result or merged store word
//  WR     | whole-word write strobe (only state with mem_wren high)
//  RESP   | resp_valid pulse for a completed access
//  ERR    | resp_valid + resp_err pulse; memory never touched
module lsu_rmw
   import lsu_rmw_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [2:0]       req_funct3,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wren,
   output logic [WIDTH-1:0] mem_wr_data,
   output logic [2:0]       mem_funct3,
   input  logic [WIDTH-1:0] mem_rd_data
);

   if (WIDTH != 32) begin : g_width_check
      $error("lsu_rmw supports only WIDTH=32");
   end

   lsu_state_t       state;
   logic             we_q;
   funct3_t          f3_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] wr_word_q;
   logic [WIDTH-1:0] rdata_q;

   logic [1:0]       lane_lo;
   funct3_t          lane_f3;
   logic             lane_we;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] merged;
   logic             misaligned;

   // One lane unit serves both jobs: in IDLE it judges the incoming request,
   // afterwards it works on the latched request and the returned read word
   always_comb begin
      lane_lo = addr_q[1:0];
      lane_f3 = f3_q;
      lane_we = we_q;
      if (state == S_IDLE) begin
         lane_lo = req_addr[1:0];
         lane_f3 = req_funct3;
         lane_we = req_we;
      end
   end

   lsu_lane_align u_lane (
      .word       (mem_rd_data),
      .wdata      (wdata_q),
      .addr_lo    (lane_lo),
      .funct3     (lane_f3),
      .we         (lane_we),
      .load_data  (load_data),
      .merged     (merged),
      .misaligned (misaligned)
   );

   // Outputs decoded from state so a reset drops mem_wren without waiting for a clock
   always_comb begin
      req_ready   = (state == S_IDLE);
      resp_valid  = (state == S_RESP) || (state == S_ERR);
      resp_err    = (state == S_ERR);
      resp_rdata  = rdata_q;
      mem_wren    = (state == S_WR);
      mem_addr    = {addr_q[WIDTH-1:2], 2'b00};
      mem_wr_data = wr_word_q;
      mem_funct3  = F3_WORD;
   end

   // Request sequencing; resp_rdata only changes when a response is issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         we_q      <= 1'b0;
         f3_q      <= F3_WORD;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_word_q <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (misaligned) begin
                     rdata_q <= '0;
                     state   <= S_ERR;
                  end else if (req_we && (req_funct3 == F3_WORD)) begin
                     wr_word_q <= req_wdata;
                     state     <= S_WR;
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_RD:   state <= S_CAP;
            S_CAP: begin
               if (we_q) begin
                  wr_word_q <= merged;
                  state     <= S_WR;
               end else begin
                  rdata_q <= load_data;
                  state   <= S_RESP;
               end
            end
            S_WR: begin
               rdata_q <= '0;
               state   <= S_RESP;
            end
            S_RESP: state <= S_IDLE;
            S_ERR:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: 1-cycle-latency word RAM, directed cases, reset during
// a write, back-to-back requests and a randomized run against a reference.
module tb_lsu_rmw;
   import lsu_rmw_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wr_data;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rd_data;

   int tests = 0;
   int fails = 0;

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;

   always #5 clk = ~clk;

   lsu_rmw #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_funct3  (req_funct3),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_addr    (mem_addr),
      .mem_wren    (mem_wren),
      .mem_wr_data (mem_wr_data),
      .mem_funct3  (mem_funct3),
      .mem_rd_data (mem_rd_data)
   );

   // Word RAM: synchronous write, read data one cycle after the address
   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      else if (mem_wren) ram[mem_addr[9:2]] <= mem_wr_data;
      mem_rd_data <= ram[mem_addr[9:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_illegal(input logic we, input logic [31:0] a, input logic [2:0] f3);
      int sz;
      case (f3)
         3'd0, 3'd4: sz = 1;
         3'd1, 3'd5: sz = 2;
         3'd2:       sz = 4;
         default:    return 1'b1;
      endcase
      if (we && f3 >= 3'd4) return 1'b1;
      return (a % sz) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * (a % 4))) & 32'hFF;
      h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] mask;
      int sh;
      if (f3 == 3'd0) begin
         sh = 8 * (a % 4);
         mask = 32'hFF << sh;
      end else if (f3 == 3'd1) begin
         sh = 16 * ((a % 4) / 2);
         mask = 32'hFFFF << sh;
      end else begin
         return wd;
      end
      return (w & ~mask) | ((wd << sh) & mask);
   endfunction

   // Issue one request, then watch for the response within a cycle budget
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, output int lat, output logic [31:0] rd,
                         output logic er, output int wrn);
      @(negedge clk);
      for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; wrn = 0; rd = 'x; er = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         if (mem_wren) wrn++;
         if (resp_valid) begin
            lat = i; rd = resp_rdata; er = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_and_check(input string tag, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3, output logic [31:0] rd);
      int lat, wrn, exp_lat, exp_wrn;
      logic er, ill;
      logic [31:0] exp_rd;
      ill = ref_illegal(we, addr, f3);
      exp_rd  = (!ill && !we) ? ref_load(ref_mem[addr[9:2]], addr, f3) : 32'h0;
      exp_lat = ill ? 1 : (!we ? 3 : (f3 == 3'd2 ? 2 : 4));
      exp_wrn = (!ill && we) ? 1 : 0;
      do_req(we, addr, wd, f3, lat, rd, er, wrn);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " err"}, {31'h0, er}, {31'h0, ill});
      chk({tag, " rdata"}, rd, exp_rd);
      chk({tag, " wren cycles"}, wrn, exp_wrn);
      if (!ill && we) ref_mem[addr[9:2]] = ref_store(ref_mem[addr[9:2]], addr, wd, f3);
   endtask

   initial begin
      logic [31:0] rd;
      int acc, nresp, wait_cnt;
      logic we;
      logic [31:0] addr;
      logic [2:0] f3;

      // Preload RAM and reference while held in reset
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pre_we = 1'b1; pre_idx = i[7:0];
         pre_data = (i == 64) ? 32'h8899AABB : $urandom;
         ref_mem[i] = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;

      chk("reset req_ready", {31'h0, req_ready}, 32'h1);
      chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("reset resp_err", {31'h0, resp_err}, 32'h0);
      chk("reset resp_rdata", resp_rdata, 32'h0);
      chk("reset mem_wren", {31'h0, mem_wren}, 32'h0);
      chk("reset mem_addr", mem_addr, 32'h0);
      chk("reset mem_wr_data", mem_wr_data, 32'h0);
      chk("mem_funct3 word", {29'h0, mem_funct3}, 32'h2);
      rst = 1'b1;

      // Loads with sign/zero extension
      run_and_check("LB 101", 1'b0, 32'h101, 32'h0, 3'd0, rd);
      chk("LB 101 value", rd, 32'hFFFFFFAA);
      run_and_check("LBU 103", 1'b0, 32'h103, 32'h0, 3'd4, rd);
      chk("LBU 103 value", rd, 32'h00000088);
      run_and_check("LH 102", 1'b0, 32'h102, 32'h0, 3'd1, rd);
      chk("LH 102 value", rd, 32'hFFFF8899);
      run_and_check("LHU 100", 1'b0, 32'h100, 32'h0, 3'd5, rd);
      chk("LHU 100 value", rd, 32'h0000AABB);
      run_and_check("LW 100", 1'b0, 32'h100, 32'h0, 3'd2, rd);
      chk("LW 100 value", rd, 32'h8899AABB);

      // Read-modify-write stores
      run_and_check("SB 102", 1'b1, 32'h102, 32'hDEADBE11, 3'd0, rd);
      @(negedge clk);
      chk("SB 102 memory", ram[64], 32'h8811AABB);
      run_and_check("SH 100", 1'b1, 32'h100, 32'hCAFE2233, 3'd1, rd);
      @(negedge clk);
      chk("SH 100 memory", ram[64], 32'h88112233);

      // Illegal accesses never touch memory
      run_and_check("LW 101", 1'b0, 32'h101, 32'h0, 3'd2, rd);
      run_and_check("SH 103", 1'b1, 32'h103, 32'h5555, 3'd1, rd);
      @(negedge clk);
      chk("illegal memory kept", ram[64], 32'h88112233);

      // Reset asserted while the SB write strobe is high
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h101; req_wdata = 32'h55; req_funct3 = 3'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_cnt = 0;
      while (!mem_wren && wait_cnt < 8) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      chk("SB reached WR", {31'h0, mem_wren}, 32'h1);
      rst = 1'b0;
      #1;
      chk("reset drops wren", {31'h0, mem_wren}, 32'h0);
      chk("reset mid-op ready", {31'h0, req_ready}, 32'h1);
      chk("reset mid-op mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready after release", {31'h0, req_ready}, 32'h1);
      chk("aborted SB memory", ram[64], 32'h88112233);

      // req_valid held high: one accept per IDLE visit
      acc = 0; nresp = 0;
      req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'd2; req_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (req_ready) acc++;
         if (resp_valid) begin
            nresp++;
            chk("held LW value", resp_rdata, 32'h88112233);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("held accepts", acc, 32'd4);
      chk("held responses", nresp, 32'd4);

      // Randomized mix of legal and illegal accesses
      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom_range(0, 1));
         addr = 32'h100 + $urandom_range(0, 63);
         f3   = 3'($urandom_range(0, 7));
         run_and_check($sformatf("rnd%0d", i), we, addr, $urandom, f3, rd);
      end
      @(negedge clk);
      for (int i = 64; i < 80; i++) chk($sformatf("final ram[%0d]", i), ram[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
